// File: rtl/mcs51_uart_peer.sv
// mcs51_uart_peer: off-chip UART transceiver facing the 8051 serial pins.
// Decodes frames arriving on rxd_in (MCU TXD) and generates frames on
// txd_out (MCU RXD). Mode 1 uses 10-bit frames; modes 2/3 add a 9th bit.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   nine_bit                     frame format, latched at each frame start
//   rxd_in / txd_out             serial lines (txd_out idles high)
//   tx_valid/tx_ready/tx_data/tx_bit9/tx_done      transmit handshake
//   rx_valid/rx_ready/rx_data/rx_bit9/rx_frame_err  receive handshake
//   rx_overrun                   sticky frame-dropped flag
module mcs51_uart_peer #(
  parameter int unsigned CLKS_PER_BIT = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nine_bit,
  input  logic       rxd_in,
  output logic       txd_out,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_bit9,
  output logic       tx_done,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_bit9,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_ZERO = TW'(0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_BIT9, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t          tx_state_q, tx_state_d;
  logic [TW-1:0]   tx_timer_q, tx_timer_d;
  logic [2:0]      tx_cnt_q, tx_cnt_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_b9_q, tx_b9_d;
  logic            tx_nine_q, tx_nine_d;
  logic            txd_q, txd_d;
  logic            tx_ready_q, tx_ready_d;
  logic            tx_done_q, tx_done_d;

  // TX state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= S_IDLE;
      tx_timer_q <= T_ZERO;
      tx_cnt_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_b9_q    <= 1'b0;
      tx_nine_q  <= 1'b0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_timer_q <= tx_timer_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_b9_q    <= tx_b9_d;
      tx_nine_q  <= tx_nine_d;
      txd_q      <= txd_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // TX next state: txd_d is the level for the next bit period, set on the
  // cycle the current period expires so the line changes exactly on time.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = tx_timer_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_b9_d    = tx_b9_q;
    tx_nine_d  = tx_nine_q;
    txd_d      = txd_q;
    tx_ready_d = tx_ready_q;
    tx_done_d  = 1'b0;
    if (tx_state_q == S_IDLE) begin
      if (tx_valid && tx_ready_q) begin
        tx_shift_d = tx_data;
        tx_b9_d    = tx_bit9;
        tx_nine_d  = nine_bit;
        tx_timer_d = T_FULL;
        txd_d      = 1'b0;
        tx_ready_d = 1'b0;
        tx_state_d = S_START;
      end
    end else if (tx_timer_q != T_ZERO) begin
      tx_timer_d = tx_timer_q - T_ONE;
      // registered pulse must land on the final stop cycle
      if (tx_state_q == S_STOP && tx_timer_q == T_ONE) tx_done_d = 1'b1;
    end else begin
      tx_timer_d = T_FULL;
      case (tx_state_q)
        S_START: begin
          tx_cnt_d   = 3'd0;
          txd_d      = tx_shift_q[0];
          tx_state_d = S_DATA;
        end
        S_DATA: begin
          if (tx_cnt_q == 3'd7) begin
            txd_d      = tx_nine_q ? tx_b9_q : 1'b1;
            tx_state_d = tx_nine_q ? S_BIT9 : S_STOP;
          end else begin
            tx_cnt_d   = tx_cnt_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end
        S_BIT9: begin
          txd_d      = 1'b1;
          tx_state_d = S_STOP;
        end
        default: begin
          tx_ready_d = 1'b1;
          tx_state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic            rx_sync1_q, rx_sync2_q, rx_prev_q;
  state_t          rx_state_q, rx_state_d;
  logic [TW-1:0]   rx_timer_q, rx_timer_d;
  logic [2:0]      rx_cnt_q, rx_cnt_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_b9s_q, rx_b9s_d;
  logic            rx_nine_q, rx_nine_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_bit9_q, rx_bit9_d;
  logic            rx_ferr_q, rx_ferr_d;
  logic            rx_ovr_q, rx_ovr_d;
  logic            rx_cur_c;

  assign rx_cur_c = rx_sync2_q;

  // RX synchronizer and state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_timer_q <= T_ZERO;
      rx_cnt_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_b9s_q   <= 1'b0;
      rx_nine_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_bit9_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_sync1_q <= rxd_in;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_timer_q <= rx_timer_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_b9s_q   <= rx_b9s_d;
      rx_nine_q  <= rx_nine_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_bit9_q  <= rx_bit9_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  // RX next state: half-bit delay after the edge, then sample mid-bit
  always_comb begin
    rx_state_d = rx_state_q;
    rx_timer_d = rx_timer_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_b9s_d   = rx_b9s_q;
    rx_nine_d  = rx_nine_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_bit9_d  = rx_bit9_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (rx_state_q == S_IDLE) begin
      if (rx_prev_q && !rx_cur_c) begin
        rx_timer_d = T_HALF;
        rx_nine_d  = nine_bit;
        rx_b9s_d   = 1'b0;
        rx_cnt_d   = 3'd0;
        rx_state_d = S_START;
      end
    end else if (rx_timer_q != T_ZERO) begin
      rx_timer_d = rx_timer_q - T_ONE;
    end else begin
      rx_timer_d = T_FULL;
      case (rx_state_q)
        S_START: begin
          rx_state_d = rx_cur_c ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          rx_shift_d = {rx_cur_c, rx_shift_q[7:1]};
          if (rx_cnt_q == 3'd7) rx_state_d = rx_nine_q ? S_BIT9 : S_STOP;
          else                  rx_cnt_d   = rx_cnt_q + 3'd1;
        end
        S_BIT9: begin
          rx_b9s_d   = rx_cur_c;
          rx_state_d = S_STOP;
        end
        default: begin
          rx_state_d = S_IDLE;
          // a same-cycle accept frees the holding slot for the new frame
          if (!rx_valid_q || rx_ready) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
            rx_bit9_d  = rx_nine_q & rx_b9s_q;
            rx_ferr_d  = ~rx_cur_c;
          end else begin
            rx_ovr_d   = 1'b1;
          end
        end
      endcase
    end
  end

  assign txd_out      = txd_q;
  assign tx_ready     = tx_ready_q;
  assign tx_done      = tx_done_q;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign rx_bit9      = rx_bit9_q;
  assign rx_frame_err = rx_ferr_q;
  assign rx_overrun   = rx_ovr_q;

endmodule

// File: tb/tb_mcs51_uart_peer.sv
// Scoreboard bench for mcs51_uart_peer: stimulus pushes expected TX frames
// and RX deliveries; two monitors pop and compare as the DUT presents them.
module tb_mcs51_uart_peer;

  localparam int CPB = 32;

  logic       clk, reset_n, nine_bit, tx_valid, tx_bit9, rx_ready;
  logic [7:0] tx_data;
  logic       txd_out, tx_ready, tx_done, rx_valid, rx_bit9, rx_frame_err, rx_overrun;
  logic [7:0] rx_data;
  logic       loop_en, rxd_drv, rxd_w;

  assign rxd_w = loop_en ? txd_out : rxd_drv;

  mcs51_uart_peer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset_n(reset_n), .nine_bit(nine_bit), .rxd_in(rxd_w),
    .txd_out(txd_out), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_bit9(tx_bit9), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_bit9(rx_bit9), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  typedef struct { logic [7:0] data; logic bit9; logic nine; } tx_exp_t;
  typedef struct { logic [7:0] data; logic bit9; logic ferr; } rx_exp_t;

  tx_exp_t txq[$];
  rx_exp_t rxq[$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Checks a whole frame starting at the negedge of its first low cycle.
  task automatic tx_check_frame(input tx_exp_t e);
    logic lvl;
    logic exp_done;
    int   nbits;
    int   good;
    nbits = e.nine ? 11 : 10;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)                lvl = 1'b0;
      else if (b <= 8)           lvl = e.data[b-1];
      else if (b == 9 && e.nine) lvl = e.bit9;
      else                       lvl = 1'b1;
      good = 0;
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (!reset_n) return;
        exp_done = (b == nbits - 1) && (c == CPB - 1);
        if (txd_out === lvl && tx_done === exp_done) good++;
      end
      chk($sformatf("tx_0x%0h_bit%0d_cycles", e.data, b), 32'(good), 32'(CPB));
    end
    @(negedge clk);
    if (!reset_n) return;
    chk("tx_ready_after_done", 32'({tx_ready, tx_done}), 32'(2'b10));
  endtask

  // TX monitor
  initial begin : tx_mon
    logic    prev;
    tx_exp_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b1;
        continue;
      end
      if (prev && !txd_out) begin
        if (txq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_frame: got start bit expected idle line");
        end else begin
          e = txq.pop_front();
          tx_check_frame(e);
        end
      end
      prev = txd_out;
    end
  end

  // RX monitor: compares each frame as the consumer accepts it
  initial begin : rx_mon
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && rx_valid && rx_ready) begin
        if (rxq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected_frame: got data 0x%0h expected none", rx_data);
        end else begin
          e = rxq.pop_front();
          chk("rx_frame", 32'({rx_data, rx_bit9, rx_frame_err}), 32'({e.data, e.bit9, e.ferr}));
        end
      end
    end
  end

  task automatic send_tx(input logic [7:0] d, input logic b9, input logic nb);
    tx_exp_t e;
    int n;
    n = 0;
    while (!tx_ready && n < 1000) begin
      tick(1);
      n++;
    end
    chk("tx_ready_before_send", 32'(tx_ready), 32'(1));
    e.data = d; e.bit9 = b9; e.nine = nb;
    txq.push_back(e);
    tx_data = d; tx_bit9 = b9; nine_bit = nb; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    chk("tx_ready_low_after_accept", 32'(tx_ready), 32'(0));
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic b9, input logic nb, input logic stopb);
    logic [10:0] bits;
    int nbits;
    nbits = nb ? 11 : 10;
    bits = nb ? {stopb, b9, d, 1'b0} : {1'b1, stopb, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rxd_drv = bits[i];
      tick(CPB);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic expect_rx(input logic [7:0] d, input logic b9, input logic ferr);
    rx_exp_t e;
    e.data = d; e.bit9 = b9; e.ferr = ferr;
    rxq.push_back(e);
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin : watchdog
    #(50000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset_n = 1'b0; nine_bit = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tx_bit9 = 1'b0; rx_ready = 1'b0; loop_en = 1'b0; rxd_drv = 1'b1;
    tick(3);
    chk("rst_txd_out", 32'(txd_out), 32'(1));
    chk("rst_tx_ready", 32'(tx_ready), 32'(1));
    chk("rst_tx_done", 32'(tx_done), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_rx_bit9", 32'(rx_bit9), 32'(0));
    chk("rst_rx_frame_err", 32'(rx_frame_err), 32'(0));
    chk("rst_rx_overrun", 32'(rx_overrun), 32'(0));
    reset_n = 1'b1;
    tick(5);

    // mode 1 byte; a request while busy must be ignored
    send_tx(8'hA5, 1'b0, 1'b0);
    tick(100);
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(10 * CPB - 101 + 20);
    chk("tx_queue_after_a5", 32'(txq.size()), 32'(0));

    // 9-bit frame; nine_bit flips mid-frame without effect
    send_tx(8'h00, 1'b1, 1'b1);
    tick(50);
    nine_bit = 1'b0;
    tick(11 * CPB - 50 + 20);
    nine_bit = 1'b1;
    chk("tx_queue_after_9bit", 32'(txq.size()), 32'(0));

    // loopback, 9-bit
    loop_en = 1'b1;
    rx_ready = 1'b1;
    expect_rx(8'h3C, 1'b0, 1'b0);
    send_tx(8'h3C, 1'b0, 1'b1);
    tick(11 * CPB + 40);
    loop_en = 1'b0;
    chk("loopback_rx_delivered", 32'(rxq.size()), 32'(0));

    // false start, then a clean frame proves the receiver is idle again
    nine_bit = 1'b0;
    rxd_drv = 1'b0;
    tick(8);
    rxd_drv = 1'b1;
    tick(12 * CPB);
    chk("false_start_no_valid", 32'(rx_valid), 32'(0));
    expect_rx(8'h81, 1'b0, 1'b0);
    drive_rx(8'h81, 1'b0, 1'b0, 1'b1);
    tick(10);
    chk("after_false_start_rx", 32'(rxq.size()), 32'(0));

    // framing error frame is still delivered
    rx_ready = 1'b0;
    drive_rx(8'h55, 1'b0, 1'b0, 1'b0);
    tick(10);
    chk("ferr_rx_valid", 32'(rx_valid), 32'(1));
    expect_rx(8'h55, 1'b0, 1'b1);
    pulse_ready();
    chk("rx_valid_cleared", 32'(rx_valid), 32'(0));

    // overrun: second frame dropped while the first is held
    drive_rx(8'h11, 1'b0, 1'b0, 1'b1);
    tick(10);
    chk("no_overrun_single", 32'(rx_overrun), 32'(0));
    drive_rx(8'h22, 1'b0, 1'b0, 1'b1);
    tick(10);
    chk("overrun_set", 32'(rx_overrun), 32'(1));
    chk("overrun_held_data", 32'(rx_data), 32'(8'h11));
    chk("overrun_valid_held", 32'(rx_valid), 32'(1));
    expect_rx(8'h11, 1'b0, 1'b0);
    pulse_ready();
    chk("overrun_sticky", 32'(rx_overrun), 32'(1));
    chk("rx_queue_drained", 32'(rxq.size()), 32'(0));

    // reset during data bit 4 of a TX frame
    send_tx(8'hE0, 1'b0, 1'b0);
    tick(170);
    chk("txd_low_before_reset", 32'(txd_out), 32'(0));
    reset_n = 1'b0;
    #1;
    chk("txd_high_in_reset", 32'(txd_out), 32'(1));
    tick(3);
    reset_n = 1'b1;
    tick(1);
    chk("post_reset_ready_done", 32'({tx_ready, tx_done, txd_out}), 32'(3'b101));
    chk("post_reset_overrun", 32'(rx_overrun), 32'(0));
    send_tx(8'h5A, 1'b0, 1'b0);
    tick(10 * CPB + 20);
    chk("tx_queue_final", 32'(txq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
